// File: rtl/fetch_align_queue_pkg.sv
// rtl/fetch_align_queue_pkg.sv - shared word widths and queue geometry defaults
package fetch_align_queue_pkg;

  localparam int INSN_LEN   = 32;
  localparam int ADDR_LEN   = 32;
  localparam int FQ_LINE_W  = 4;
  localparam int FQ_FETCH_W = 2;
  localparam int FQ_DEPTH   = 8;

  typedef logic [INSN_LEN-1:0] insn_t;
  typedef logic [ADDR_LEN-1:0] addr_t;

endpackage

// File: rtl/fetch_align_queue_line_pack.sv
// rtl/fetch_align_queue_line_pack.sv - compacts the wanted words of a fetch line to word 0
module fq_line_pack
  import fetch_align_queue_pkg::*;
#(
  parameter int LINE_W = FQ_LINE_W,
  localparam int SW = $clog2(LINE_W),
  localparam int NW = SW + 1
) (
  input  logic [SW-1:0]            start,
  input  logic [SW-1:0]            last,
  input  logic [LINE_W*INSN_LEN-1:0] line_data,
  output logic [LINE_W*INSN_LEN-1:0] words,
  output logic [NW-1:0]            n
);

  logic [SW-1:0] src_idx [LINE_W];

  // A cut before the start word still delivers the start word alone; the
  // source index wraps so words past the cut are harmless don't-cares.
  always_comb begin
    n     = (last >= start) ? (NW'(last) - NW'(start) + NW'(1)) : NW'(1);
    words = '0;
    for (int k = 0; k < LINE_W; k++) begin
      src_idx[k] = start + SW'(k);
      words[k*INSN_LEN +: INSN_LEN] = line_data[src_idx[k]*INSN_LEN +: INSN_LEN];
    end
  end

endmodule

// File: rtl/fetch_align_queue.sv
// rtl/fetch_align_queue.sv - fetch line compaction queue feeding decode (option: FQ_PC_TRACK_EN)
module fetch_align_queue
  import fetch_align_queue_pkg::*;
#(
  parameter int LINE_W  = FQ_LINE_W,
  parameter int FETCH_W = FQ_FETCH_W,
  parameter int DEPTH   = FQ_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset_x,
  input  logic                          flush,
  input  logic                          line_valid,
  output logic                          line_ready,
  input  logic [ADDR_LEN-1:0]           line_pc,
  input  logic [$clog2(LINE_W)-1:0]     line_last,
  input  logic [LINE_W*INSN_LEN-1:0]    line_data,
  output logic [FETCH_W-1:0]            out_valid,
  output logic [FETCH_W*INSN_LEN-1:0]   out_insn,
  output logic [FETCH_W*ADDR_LEN-1:0]   out_pc,
  input  logic [$clog2(FETCH_W):0]      deq_cnt
);

  localparam int SW = $clog2(LINE_W);
  localparam int NW = SW + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]              head;
  logic [PW-1:0]              tail;
  logic [CW-1:0]              count;
  insn_t                      insn_q [DEPTH];

  logic [SW-1:0]              start;
  logic [LINE_W*INSN_LEN-1:0] packed_words;
  logic [NW-1:0]              n;
  logic                       enq;
  logic [CW-1:0]              n_enq;
  logic [CW-1:0]              deq_lim;
  logic [CW-1:0]              d;
  logic [PW-1:0]              wr_idx [LINE_W];
  logic [PW-1:0]              rd_idx [FETCH_W];

  assign start = line_pc[2 +: SW];

  fq_line_pack #(.LINE_W(LINE_W)) u_pack (
    .start     (start),
    .last      (line_last),
    .line_data (line_data),
    .words     (packed_words),
    .n         (n)
  );

  // Room for a whole line regardless of where it starts; dequeues are not credited same-cycle.
  assign line_ready = (CW'(DEPTH) - count) >= CW'(LINE_W);
  assign enq        = line_valid && line_ready && !flush;

  // Enqueue size, dequeue clamped to both the slot count and the occupancy, and slot/write indices.
  always_comb begin
    n_enq   = enq ? CW'(n) : '0;
    deq_lim = (CW'(deq_cnt) > CW'(FETCH_W)) ? CW'(FETCH_W) : CW'(deq_cnt);
    d       = (deq_lim > count) ? count : deq_lim;
    for (int k = 0; k < LINE_W; k++) wr_idx[k] = tail + PW'(k);
    for (int j = 0; j < FETCH_W; j++) rd_idx[j] = head + PW'(j);
  end

  // Pointer and occupancy update; flush wins over any concurrent line or dequeue.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(d);
      tail  <= tail + PW'(n_enq);
      count <= count + n_enq - d;
    end
  end

  // Instruction storage; contents are qualified by count so they need no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int k = 0; k < LINE_W; k++) begin
        if (NW'(k) < n) insn_q[wr_idx[k]] <= packed_words[k*INSN_LEN +: INSN_LEN];
      end
    end
  end

  // Decode slots come straight from registered state, oldest entry in slot 0.
  always_comb begin
    out_valid = '0;
    out_insn  = '0;
    for (int j = 0; j < FETCH_W; j++) begin
      if (CW'(j) < count) begin
        out_valid[j] = 1'b1;
        out_insn[j*INSN_LEN +: INSN_LEN] = insn_q[rd_idx[j]];
      end
    end
  end

`ifdef FQ_PC_TRACK_EN
  addr_t pc_q [DEPTH];

  // Compacted word k sits k words after the first wanted PC.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int k = 0; k < LINE_W; k++) begin
        if (NW'(k) < n) pc_q[wr_idx[k]] <= line_pc + ADDR_LEN'(4 * k);
      end
    end
  end

  // Slot PCs follow the same validity as the instructions.
  always_comb begin
    out_pc = '0;
    for (int j = 0; j < FETCH_W; j++) begin
      if (CW'(j) < count) out_pc[j*ADDR_LEN +: ADDR_LEN] = pc_q[rd_idx[j]];
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^{line_pc[ADDR_LEN-1:2+SW], line_pc[1:0]};
  assign out_pc    = '0;
`endif

endmodule

// File: tb/tb_fetch_align_queue.sv
// tb/tb_fetch_align_queue.sv - scoreboard bench for fetch_align_queue
module tb_fetch_align_queue;

  localparam int LINE_W  = 4;
  localparam int FETCH_W = 2;
  localparam int DEPTH   = 8;
  localparam int IL      = 32;
  localparam int AL      = 32;

  logic                    clk;
  logic                    reset_x;
  logic                    flush;
  logic                    line_valid;
  logic                    line_ready;
  logic [AL-1:0]           line_pc;
  logic [1:0]              line_last;
  logic [LINE_W*IL-1:0]    line_data;
  logic [FETCH_W-1:0]      out_valid;
  logic [FETCH_W*IL-1:0]   out_insn;
  logic [FETCH_W*AL-1:0]   out_pc;
  logic [1:0]              deq_cnt;

  int n_checks;
  int n_fail;
  logic [31:0] sb_insn [$];
  logic [31:0] sb_pc [$];
  int mon_nv;
  int mon_d;
  logic [31:0] pop_insn;
  logic [31:0] pop_pc;

  fetch_align_queue #(.LINE_W(LINE_W), .FETCH_W(FETCH_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_x    (reset_x),
    .flush      (flush),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_pc    (line_pc),
    .line_last  (line_last),
    .line_data  (line_data),
    .out_valid  (out_valid),
    .out_insn   (out_insn),
    .out_pc     (out_pc),
    .deq_cnt    (deq_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_pc(input logic [31:0] pc);
`ifdef FQ_PC_TRACK_EN
    return pc;
`else
    return 32'h0 & pc;
`endif
  endfunction

  task automatic drive_line(input logic [31:0] pc, input logic [1:0] last, input logic [31:0] base);
    line_valid = 1'b1;
    line_pc    = pc;
    line_last  = last;
    for (int i = 0; i < LINE_W; i++) line_data[i*IL +: IL] = base + 32'(i);
  endtask

  task automatic push_line(input logic [31:0] pc, input logic [1:0] last, input logic [31:0] base);
    int s;
    int n;
    s = int'(pc[3:2]);
    n = (int'(last) >= s) ? int'(last) - s + 1 : 1;
    for (int k = 0; k < n; k++) begin
      sb_insn.push_back(base + 32'(s + k));
      sb_pc.push_back(pc + 32'(4 * k));
    end
  endtask

  task automatic send_line(input logic [31:0] pc, input logic [1:0] last, input logic [31:0] base);
    bit accepted;
    accepted = 1'b0;
    drive_line(pc, last, base);
    for (int c = 0; c < 100 && !accepted; c++) begin
      @(negedge clk);
      if (line_ready) begin
        push_line(pc, last, base);
        accepted = 1'b1;
      end
      @(posedge clk); #1;
    end
    line_valid = 1'b0;
    if (!accepted) check("send_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    deq_cnt = 2'd2;
    for (int c = 0; c < 100 && !empty; c++) begin
      @(negedge clk);
      if (out_valid == '0) empty = 1'b1;
      @(posedge clk); #1;
    end
    deq_cnt = 2'd0;
    if (!empty) check("drain_timeout", 64'(empty), 64'd1);
  endtask

  task automatic check_slots(input string tag, input logic [31:0] i0, input logic [31:0] p0,
                             input logic [31:0] i1, input logic [31:0] p1);
    check({tag, "_valid"}, 64'(out_valid), 64'h3);
    check({tag, "_insn0"}, 64'(out_insn[0 +: IL]), 64'(i0));
    check({tag, "_pc0"}, 64'(out_pc[0 +: AL]), 64'(exp_pc(p0)));
    check({tag, "_insn1"}, 64'(out_insn[IL +: IL]), 64'(i1));
    check({tag, "_pc1"}, 64'(out_pc[AL +: AL]), 64'(exp_pc(p1)));
  endtask

  // Monitor: pops one scoreboard entry per slot consumed by decode.
  always @(negedge clk) begin
    if (reset_x && !flush) begin
      mon_nv = 0;
      for (int j = 0; j < FETCH_W; j++) if (out_valid[j] && mon_nv == j) mon_nv = j + 1;
      check("thermometer", 64'(out_valid), 64'((1 << mon_nv) - 1));
      for (int j = mon_nv; j < FETCH_W; j++) begin
        check($sformatf("idle_insn%0d", j), 64'(out_insn[j*IL +: IL]), 64'd0);
        check($sformatf("idle_pc%0d", j), 64'(out_pc[j*AL +: AL]), 64'd0);
      end
      mon_d = (int'(deq_cnt) < mon_nv) ? int'(deq_cnt) : mon_nv;
      for (int j = 0; j < mon_d; j++) begin
        if (sb_insn.size() == 0) begin
          check("sb_underflow", 64'(sb_insn.size()), 64'd1);
        end else begin
          pop_insn = sb_insn.pop_front();
          pop_pc   = sb_pc.pop_front();
          check($sformatf("deq_insn%0d", j), 64'(out_insn[j*IL +: IL]), 64'(pop_insn));
          check($sformatf("deq_pc%0d", j), 64'(out_pc[j*AL +: AL]), 64'(exp_pc(pop_pc)));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset_x    = 1'b0;
    flush      = 1'b0;
    line_valid = 1'b0;
    line_pc    = '0;
    line_last  = '0;
    line_data  = '0;
    deq_cnt    = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_insn", 64'(out_insn), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_ready", 64'(line_ready), 64'd1);
    @(posedge clk); #1;
    reset_x = 1'b1;
    @(posedge clk); #1;

    // Aligned line, one-cycle latency.
    send_line(32'h100, 2'd3, 32'hA000_0000);
    @(negedge clk);
    check_slots("aligned", 32'hA000_0000, 32'h100, 32'hA000_0001, 32'h104);
    check("aligned_ready", 64'(line_ready), 64'd1);
    @(posedge clk); #1;

    // Unaligned start at word 3: single entry, count becomes 5.
    send_line(32'h10C, 2'd3, 32'hB000_0000);
    @(negedge clk);
    check("count5_ready", 64'(line_ready), 64'd0);
    @(posedge clk); #1;

    // Held line while full, then one dequeue of two frees room a cycle later.
    drive_line(32'h110, 2'd3, 32'hC000_0000);
    @(negedge clk);
    check("stall_ready", 64'(line_ready), 64'd0);
    @(posedge clk); #1;
    deq_cnt = 2'd2;
    @(negedge clk);
    check("no_same_cycle_credit", 64'(line_ready), 64'd0);
    @(posedge clk); #1;
    deq_cnt = 2'd0;
    @(negedge clk);
    check("ready_after_deq", 64'(line_ready), 64'd1);
    if (line_ready) push_line(32'h110, 2'd3, 32'hC000_0000);
    @(posedge clk); #1;
    line_valid = 1'b0;
    deq_cnt = 2'd2;
    @(negedge clk);
    @(posedge clk); #1;
    deq_cnt = 2'd0;
    @(negedge clk);
    check_slots("no_gap", 32'hB000_0003, 32'h10C, 32'hC000_0000, 32'h110);
    @(posedge clk); #1;
    drain();

    // Predicted-taken cut at word 1.
    send_line(32'h200, 2'd1, 32'hE000_0000);
    @(negedge clk);
    check_slots("cut", 32'hE000_0000, 32'h200, 32'hE000_0001, 32'h204);
    @(posedge clk); #1;
    deq_cnt = 2'd2;
    @(negedge clk);
    @(posedge clk); #1;
    deq_cnt = 2'd0;
    @(negedge clk);
    check("cut_no_extra", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Flush with count 6, concurrent line and dequeue.
    send_line(32'h300, 2'd3, 32'hF000_0000);
    send_line(32'h308, 2'd3, 32'hF100_0000);
    @(negedge clk);
    check("count6_ready", 64'(line_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    drive_line(32'h400, 2'd3, 32'h4400_0000);
    deq_cnt = 2'd2;
    @(posedge clk); #1;
    flush = 1'b0;
    line_valid = 1'b0;
    deq_cnt = 2'd0;
    sb_insn.delete();
    sb_pc.delete();
    @(negedge clk);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(line_ready), 64'd1);
    @(posedge clk); #1;

    // Flush while the line would have been accepted.
    send_line(32'h500, 2'd3, 32'h5500_0000);
    flush = 1'b1;
    drive_line(32'h600, 2'd3, 32'h6600_0000);
    deq_cnt = 2'd2;
    @(posedge clk); #1;
    flush = 1'b0;
    line_valid = 1'b0;
    deq_cnt = 2'd0;
    sb_insn.delete();
    sb_pc.delete();
    @(negedge clk);
    check("flush_drops_line", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_stays_empty", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Streaming across the pointer wrap.
    deq_cnt = 2'd2;
    for (int i = 0; i < 20; i++) send_line(32'h1000 + 32'(16 * i), 2'd3, 32'h7000_0000 + 32'(i << 8));
    drain();
    check("sb_empty", 64'(sb_insn.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
